md_pad6: RTL

MD_PAD6 -- requirements
Module: md_pad6

---
 rtl/md_pad6.sv | 104 ++++++++++
 1 files changed

// File: rtl/md_pad6.sv
// md_pad6: Mega Drive joypad on port A, MCLK domain, registered pin levels back to the I/O controller.
// Build option MD_PAD_SIX_BUTTON_EN adds the 6-button TH phase counter and idle timeout.
module md_pad6 #(
   parameter int unsigned TIMEOUT = 80000
) (
   input  logic        MCLK,
   input  logic        ext_reset,
   input  logic [6:0]  PA_o,
   input  logic [6:0]  PA_d,
   input  logic [11:0] buttons,
   output logic [6:0]  PA_i
);

   logic       w_th;
   logic [2:0] w_l;
   logic [5:0] w_p;
   logic [6:0] w_pa_nxt;

   if (TIMEOUT > 32'h0001_ffff) begin : g_timeout_range
      $error("TIMEOUT does not fit the 17-bit idle counter");
   end

   // A released TH pin floats high through the pad pull-up.
   assign w_th = PA_d[6] | PA_o[6];

`ifdef MD_PAD_SIX_BUTTON_EN
   localparam logic [16:0] C_TIMEOUT = 17'(TIMEOUT);

   logic        r_th_q;
   logic        w_fall;
   logic        w_rise;
   logic [16:0] r_idle;
   logic [16:0] w_idle_nxt;
   logic [2:0]  r_l;
   logic [2:0]  w_l_nxt;

   assign w_fall = r_th_q & ~w_th;
   assign w_rise = ~r_th_q & w_th;

   // A TH edge takes priority over a timeout landing in the same cycle.
   always_comb begin
      w_idle_nxt = r_idle;
      w_l_nxt    = r_l;
      if (w_fall || w_rise) begin
         w_idle_nxt = '0;
         if (w_fall) begin
            w_l_nxt = (r_l == 3'd4) ? 3'd0 : r_l + 3'd1;
         end
      end else begin
         if (r_idle < C_TIMEOUT) begin
            w_idle_nxt = r_idle + 17'd1;
         end
         if (w_idle_nxt == C_TIMEOUT) begin
            w_l_nxt = '0;
         end
      end
   end

   always_ff @(posedge MCLK or posedge ext_reset) begin
      if (ext_reset) begin
         r_th_q <= 1'b1;
         r_idle <= '0;
         r_l    <= '0;
      end else begin
         r_th_q <= w_th;
         r_idle <= w_idle_nxt;
         r_l    <= w_l_nxt;
      end
   end

   // The pad mux looks at the phase as it will be after this cycle's edge.
   assign w_l = w_l_nxt;
`else
   assign w_l = 3'd0;
`endif

   always_comb begin
      w_p = '1;
      if (w_th) begin
         if (w_l == 3'd3) begin
            w_p = ~{buttons[6], buttons[5], buttons[11], buttons[8], buttons[9], buttons[10]};
         end else begin
            w_p = ~{buttons[6], buttons[5], buttons[3], buttons[2], buttons[1], buttons[0]};
         end
      end else begin
         case (w_l)
            3'd3:    w_p = {~buttons[7], ~buttons[4], 4'h0};
            3'd4:    w_p = {~buttons[7], ~buttons[4], 4'hf};
            default: w_p = {~buttons[7], ~buttons[4], 2'b00, ~buttons[1], ~buttons[0]};
         endcase
      end
   end

   assign w_pa_nxt = {w_th, (PA_d[5:0] & w_p) | (~PA_d[5:0] & PA_o[5:0])};

   always_ff @(posedge MCLK or posedge ext_reset) begin
      if (ext_reset) begin
         PA_i <= 7'h7f;
      end else begin
         PA_i <= w_pa_nxt;
      end
   end

endmodule
